// File: rtl/sparsity_flag_scanner_if.sv
// sparsity_flag_scanner_if: flag-loader write port and block-index consumer port
interface sparsity_flag_scanner_if #(
  parameter int NUM_BLOCK  = 16,
  parameter int ADDR_WIDTH = 3,
  parameter int IDX_WIDTH  = 4
);
  logic                  wr_req;
  logic [NUM_BLOCK-1:0]  wr_data;
  logic                  wr_full;
  logic                  wr_overflow;
  logic [ADDR_WIDTH:0]   fill_cnt;
  logic                  rd_ready;
  logic                  out_valid;
  logic [IDX_WIDTH-1:0]  out_idx;
  logic                  out_last;
  logic                  zero_word;
  modport master (
    output wr_req, wr_data, rd_ready,
    input  wr_full, wr_overflow, fill_cnt, out_valid, out_idx, out_last, zero_word
  );
  modport slave (
    input  wr_req, wr_data, rd_ready,
    output wr_full, wr_overflow, fill_cnt, out_valid, out_idx, out_last, zero_word
  );
endinterface

// File: rtl/sparsity_flag_scanner.sv
// sparsity_flag_scanner: FIFO of block-valid flag words scanned into nonzero block indices.
// Define SPARSITY_STATS_EN to add the saturating zero_cnt statistics output.
module sparsity_flag_scanner #(
  parameter int NUM_BLOCK  = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int IDX_WIDTH  = 4
) (
  input logic clk,
  input logic rst,
  input logic clk_en,
  input logic flush,
  sparsity_flag_scanner_if.slave b
`ifdef SPARSITY_STATS_EN
  ,
  output logic [31:0] zero_cnt
`endif
);
  typedef enum logic {IDLE, SCAN} state_t;
  state_t state_q, state_d;
  logic [NUM_BLOCK-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0] cnt_q, cnt_d;
  logic [NUM_BLOCK-1:0] mask_q, mask_d, head;
  logic [IDX_WIDTH-1:0] idx;
  logic zero_q, zero_d, ovf_q, full, nonempty, wr_acc, pop, hs, last;
  assign full     = cnt_q == (ADDR_WIDTH+1)'(DEPTH);
  assign nonempty = cnt_q != '0;
  assign wr_acc   = clk_en & b.wr_req & ~full;
  assign head     = mem[rd_ptr_q];
  assign hs       = clk_en & (state_q == SCAN) & b.rd_ready;
  assign last     = (mask_q & (mask_q - NUM_BLOCK'(1))) == '0;
  assign cnt_d    = cnt_q + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(pop);
  always_comb begin
    idx = '0;
    for (int i = NUM_BLOCK - 1; i >= 0; i--) if (mask_q[i]) idx = IDX_WIDTH'(i);
  end
  // A finished word hands straight over to a nonzero head word so the consumer sees no bubble.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    zero_d  = 1'b0;
    pop     = 1'b0;
    if (state_q == IDLE) begin
      pop = clk_en & nonempty;
      if (pop) begin
        mask_d  = head;
        state_d = head != '0 ? SCAN : IDLE;
        zero_d  = head == '0;
      end
    end else if (hs) begin
      mask_d = mask_q & (mask_q - NUM_BLOCK'(1));
      if (last) begin
        pop     = nonempty;
        mask_d  = nonempty ? head : '0;
        state_d = (nonempty && head != '0) ? SCAN : IDLE;
        zero_d  = nonempty && head == '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (clk_en) begin
      state_q <= state_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      ovf_q   <= b.wr_req & full;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
    end
  end
  always_ff @(posedge clk) if (wr_acc) mem[wr_ptr_q] <= b.wr_data;
  assign b.out_valid   = state_q == SCAN;
  assign b.out_idx     = idx;
  assign b.out_last    = (state_q == SCAN) & last;
  assign b.fill_cnt    = cnt_q;
  assign b.wr_full     = full;
  assign b.wr_overflow = ovf_q;
  assign b.zero_word   = zero_q;
`ifdef SPARSITY_STATS_EN
  logic [31:0] zc_q;
  logic [IDX_WIDTH:0] zeros;
  logic [32:0] zsum;
  always_comb begin
    zeros = '0;
    for (int i = 0; i < NUM_BLOCK; i++) zeros = zeros + (IDX_WIDTH+1)'(~head[i]);
  end
  assign zsum = {1'b0, zc_q} + 33'(zeros);
  always_ff @(posedge clk) begin
    if (rst || flush) zc_q <= '0;
    else if (pop) zc_q <= zsum[32] ? 32'hFFFF_FFFF : zsum[31:0];
  end
  assign zero_cnt = zc_q;
`endif
endmodule

// File: tb/tb_sparsity_flag_scanner.sv
// tb_sparsity_flag_scanner: directed plus random checks against a queue-based reference model.
module tb_sparsity_flag_scanner;
  localparam int NB = 16;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b0, flush = 1'b0;
  int vectors = 0, miscompares = 0;
  sparsity_flag_scanner_if #(.NUM_BLOCK(NB), .ADDR_WIDTH(3), .IDX_WIDTH(4)) b();
`ifdef SPARSITY_STATS_EN
  logic [31:0] zero_cnt;
`endif
  sparsity_flag_scanner #(.NUM_BLOCK(NB), .DEPTH(DEPTH), .ADDR_WIDTH(3), .IDX_WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .flush(flush),
    .b(b)
`ifdef SPARSITY_STATS_EN
    ,
    .zero_cnt(zero_cnt)
`endif
  );
  always #5 clk = ~clk;
  logic [NB-1:0] q[$];
  logic [NB-1:0] m;
  logic mz, mo;
  longint zc;
  int seen[$];
  function automatic int lowest(input logic [NB-1:0] v);
    for (int i = 0; i < NB; i++) if (v[i]) return i;
    return 0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_clear();
    q.delete();
    m = '0;
    mz = 1'b0;
    mo = 1'b0;
    zc = 0;
  endtask
  task automatic model_pop(output logic [NB-1:0] w);
    w = q.pop_front();
    zc = zc + (NB - $countones(w));
    if (zc > 64'hFFFF_FFFF) zc = 64'hFFFF_FFFF;
  endtask
  task automatic model(input logic wr, input logic [NB-1:0] d, input logic rr, input logic en, input logic fl);
    logic acc;
    logic [NB-1:0] w;
    if (fl) begin
      model_clear();
      return;
    end
    if (!en) return;
    acc = wr && q.size() < DEPTH;
    mo = wr && !acc;
    mz = 1'b0;
    if (m == '0) begin
      if (q.size() > 0) begin
        model_pop(w);
        if (w == '0) mz = 1'b1; else m = w;
      end
    end else if (rr) begin
      m = m & (m - 1);
      if (m == '0 && q.size() > 0) begin
        model_pop(w);
        if (w == '0) mz = 1'b1; else m = w;
      end
    end
    if (acc) q.push_back(d);
  endtask
  task automatic compare();
    chk("out_valid", b.out_valid, m != '0);
    chk("out_idx", b.out_idx, lowest(m));
    chk("out_last", b.out_last, $countones(m) == 1);
    chk("fill_cnt", b.fill_cnt, q.size());
    chk("wr_full", b.wr_full, q.size() == DEPTH);
    chk("zero_word", b.zero_word, mz);
    chk("wr_overflow", b.wr_overflow, mo);
`ifdef SPARSITY_STATS_EN
    chk("zero_cnt", zero_cnt, zc[31:0]);
`endif
  endtask
  task automatic cycle(input logic wr, input logic [NB-1:0] d, input logic rr,
                       input logic en = 1'b1, input logic fl = 1'b0);
    b.wr_req = wr;
    b.wr_data = d;
    b.rd_ready = rr;
    clk_en = en;
    flush = fl;
    @(posedge clk);
    model(wr, d, rr, en, fl);
    #1;
    compare();
  endtask
  initial begin
    logic [3:0] held;
    logic [NB-1:0] d;
    b.wr_req = 1'b0;
    b.wr_data = '0;
    b.rd_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    compare();
    cycle(0, '0, 0, 1, 1);
    cycle(1, 16'h8005, 1);
    chk("t1_fill", b.fill_cnt, 1);
    cycle(0, '0, 1);
    chk("t1_idx0", b.out_idx, 0);
    cycle(0, '0, 1);
    chk("t1_idx2", b.out_idx, 2);
    cycle(0, '0, 1);
    chk("t1_idx15", b.out_idx, 15);
    chk("t1_last", b.out_last, 1);
    cycle(0, '0, 1);
    chk("t1_idle", b.out_valid, 0);
    cycle(0, '0, 0, 1, 1);
    cycle(1, 16'h0000, 1);
    cycle(1, 16'h0001, 1);
    chk("t2_zero_pulse", b.zero_word, 1);
    cycle(0, '0, 1);
    chk("t2_idx", {b.out_valid, b.out_last, b.out_idx}, 6'h30);
    chk("t2_zero_once", b.zero_word, 0);
`ifdef SPARSITY_STATS_EN
    chk("t2_zero_cnt", zero_cnt, 31);
`endif
    cycle(0, '0, 1);
    cycle(0, '0, 0, 1, 1);
    for (int i = 0; i < 10; i++) cycle(1, NB'(1) << i, 0);
    chk("t3_fill", b.fill_cnt, 8);
    chk("t3_full", b.wr_full, 1);
    chk("t3_ovf", b.wr_overflow, 1);
    seen.delete();
    for (int i = 0; i < 20; i++) begin
      if (b.out_valid) seen.push_back(b.out_idx);
      cycle(0, '0, 1);
    end
    chk("t3_drain_n", seen.size(), 9);
    foreach (seen[i]) chk("t3_order", seen[i], i);
    cycle(0, '0, 0, 1, 1);
    cycle(1, 16'h0003, 1);
    cycle(1, 16'h0100, 1);
    chk("t4_idx0", b.out_idx, 0);
    cycle(0, '0, 1);
    chk("t4_idx1", b.out_idx, 1);
    cycle(0, '0, 1);
    chk("t4_idx8", {b.out_valid, b.out_idx}, 5'h18);
    cycle(0, '0, 1);
    cycle(1, 16'hFF00, 0);
    cycle(1, 16'h1234, 0);
    cycle(1, 16'h0F00, 0);
    cycle(1, 16'h0042, 0);
    chk("t5_queued", b.fill_cnt, 3);
    chk("t5_idx8", b.out_idx, 8);
    cycle(0, '0, 0, 1, 1);
    chk("t5_flush", {b.out_valid, b.fill_cnt}, 0);
    cycle(1, 16'h0010, 1);
    cycle(0, '0, 1);
    chk("t5_idx4", {b.out_valid, b.out_idx}, 5'h14);
    cycle(0, '0, 1);
    cycle(1, 16'h0F0F, 1);
    cycle(0, '0, 1);
    held = b.out_idx;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 16'hFFFF, 1, 0);
      chk("t6_hold", b.out_idx, held);
      chk("t6_fill", b.fill_cnt, 0);
    end
    cycle(0, '0, 1);
    chk("t6_resume", b.out_idx, 1);
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 3))
        0: d = '0;
        1: d = NB'(1) << $urandom_range(0, NB - 1);
        default: d = NB'($urandom) & NB'($urandom);
      endcase
      cycle($urandom_range(0, 2) != 0, d, $urandom_range(0, 3) != 0,
            $urandom_range(0, 9) != 0, $urandom_range(0, 63) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
